// File: rtl/cs2fifoc_if.sv
`default_nettype none
// ============================================================================
//  cs2fifoc_if : command-frame handshake, field and FIFO-write bundle
//  Revision    : 1.0
// ============================================================================
interface cs2fifoc_if;
    logic       fs;
    logic       fd;
    logic       err;
    logic       fifoc_full;
    logic       fifoc_txen;
    logic [7:0] fifoc_txd;
    logic [7:0] kind_dev;
    logic [7:0] info_sr;
    logic [7:0] cmd_filt;
    logic [7:0] cmd_mix0;
    logic [7:0] cmd_mix1;
    logic [7:0] cmd_reg4;
    logic [7:0] cmd_reg5;
    logic [7:0] cmd_reg6;
    logic [7:0] cmd_reg7;

    modport master (
        output fs, fifoc_full,
        output kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_mix1,
        output cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7,
        input  fd, err, fifoc_txen, fifoc_txd
    );

    modport slave (
        input  fs, fifoc_full,
        input  kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_mix1,
        input  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7,
        output fd, err, fifoc_txen, fifoc_txd
    );
endinterface
`default_nettype wire

// File: rtl/cs2fifoc.sv
`default_nettype none
// ============================================================================
//  cs2fifoc : snapshots nine command fields and writes a 12-byte framed
//             command (header, payload, mod-256 checksum) into the FIFO
//  Revision : 1.0
// ============================================================================
module cs2fifoc #(
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter logic [15:0] TMO_CYC = 16'd1024
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cs2fifoc_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_LAST = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state_q;
    logic [3:0]      idx_q;
    logic [7:0]      check_q;
    logic [15:0]     stall_q;
    logic [8:0][7:0] shadow_q;   // payload bytes in transmit order
    logic            txen_q;
    logic [7:0]      txd_q;
    logic [7:0]      byte_d;
    logic            payload_d;

    always_comb begin
        byte_d = 8'h00;
        case (idx_q)
            4'd0:    byte_d = HEAD0;
            4'd1:    byte_d = HEAD1;
            4'd2:    byte_d = shadow_q[0];
            4'd3:    byte_d = shadow_q[1];
            4'd4:    byte_d = shadow_q[2];
            4'd5:    byte_d = shadow_q[3];
            4'd6:    byte_d = shadow_q[4];
            4'd7:    byte_d = shadow_q[5];
            4'd8:    byte_d = shadow_q[6];
            4'd9:    byte_d = shadow_q[7];
            4'd10:   byte_d = shadow_q[8];
            4'd11:   byte_d = check_q;
            default: byte_d = 8'h00;
        endcase
    end

    assign payload_d = (idx_q >= 4'd2) && (idx_q <= 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            check_q  <= 8'h00;
            stall_q  <= 16'd0;
            shadow_q <= '0;
            txen_q   <= 1'b0;
            txd_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txen_q <= 1'b0;
                    if (bus.fs) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    txen_q   <= 1'b0;
                    shadow_q <= {bus.cmd_mix1, bus.cmd_reg7, bus.cmd_reg6, bus.cmd_reg5,
                                 bus.cmd_reg4, bus.cmd_mix0, bus.cmd_filt, bus.info_sr,
                                 bus.kind_dev};
                    idx_q    <= 4'd0;
                    check_q  <= 8'h00;
                    stall_q  <= 16'd0;
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    // The checksum byte always goes out: the FIFO keeps one entry of margin.
                    if (!bus.fifoc_full || idx_q == 4'd11) begin
                        txen_q  <= 1'b1;
                        txd_q   <= byte_d;
                        idx_q   <= idx_q + 4'd1;
                        stall_q <= 16'd0;
                        if (payload_d) check_q <= check_q + byte_d;
                        if (idx_q == 4'd11) state_q <= S_LAST;
                    end else begin
                        txen_q  <= 1'b0;
                        stall_q <= stall_q + 16'd1;
                        if (TMO_CYC != 16'd0 && stall_q == TMO_CYC - 16'd1)
                            state_q <= S_ERR;
                    end
                end
                S_LAST: begin
                    txen_q <= 1'b0;
                    if (!bus.fs) state_q <= S_IDLE;
                end
                S_ERR: begin
                    txen_q <= 1'b0;
                end
                default: begin
                    txen_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fd         = (state_q == S_LAST);
    assign bus.err        = (state_q == S_ERR);
    assign bus.fifoc_txen = txen_q;
    assign bus.fifoc_txd  = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_cs2fifoc.sv
`default_nettype none
// ============================================================================
//  tb_cs2fifoc : randomized and directed bench for the command-frame writer
//  Revision    : 1.0
// ============================================================================
module tb_cs2fifoc;

    localparam int TMO = 8;

    logic clk;
    logic rst;
    cs2fifoc_if bus();

    cs2fifoc #(.HEAD0(8'h55), .HEAD1(8'hAA), .TMO_CYC(16'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame as a byte array, position counter, run of full cycles
    int         m_mode;   // 0 idle, 1 load, 2 send, 3 done, 4 error
    int         m_pos;
    int         m_gap;
    logic [7:0] m_frame [12];
    logic       m_txen;
    logic [7:0] m_txd;
    bit         m_on = 1'b0;

    logic [7:0] cap [$];

    logic [7:0] f_seq [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic [7:0] f_ff  [9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] f_zero[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp1  [12] = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04,
                               8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h2D};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Values listed in transmit order.
    task automatic set_fields(input logic [7:0] v [9]);
        bus.kind_dev = v[0];
        bus.info_sr  = v[1];
        bus.cmd_filt = v[2];
        bus.cmd_mix0 = v[3];
        bus.cmd_reg4 = v[4];
        bus.cmd_reg5 = v[5];
        bus.cmd_reg6 = v[6];
        bus.cmd_reg7 = v[7];
        bus.cmd_mix1 = v[8];
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        m_gap  = 0;
        m_txen = 1'b0;
        m_txd  = 8'h00;
    endtask

    task automatic model_step();
        int s;
        case (m_mode)
            0: begin
                m_txen = 1'b0;
                if (bus.fs) m_mode = 1;
            end
            1: begin
                m_frame[0]  = 8'h55;
                m_frame[1]  = 8'hAA;
                m_frame[2]  = bus.kind_dev;
                m_frame[3]  = bus.info_sr;
                m_frame[4]  = bus.cmd_filt;
                m_frame[5]  = bus.cmd_mix0;
                m_frame[6]  = bus.cmd_reg4;
                m_frame[7]  = bus.cmd_reg5;
                m_frame[8]  = bus.cmd_reg6;
                m_frame[9]  = bus.cmd_reg7;
                m_frame[10] = bus.cmd_mix1;
                s = 0;
                for (int i = 2; i <= 10; i++) s += int'(m_frame[i]);
                m_frame[11] = 8'(s % 256);
                m_pos  = 0;
                m_gap  = 0;
                m_txen = 1'b0;
                m_mode = 2;
            end
            2: begin
                if (!bus.fifoc_full || m_pos == 11) begin
                    m_txen = 1'b1;
                    m_txd  = m_frame[m_pos];
                    m_pos++;
                    m_gap  = 0;
                    if (m_pos == 12) m_mode = 3;
                end else begin
                    m_txen = 1'b0;
                    m_gap++;
                    if (m_gap == TMO) m_mode = 4;
                end
            end
            3: begin
                m_txen = 1'b0;
                if (!bus.fs) m_mode = 0;
            end
            default: m_txen = 1'b0;
        endcase
    endtask

    always @(negedge clk) begin
        if (m_on && !rst) begin
            chk("txen", bus.fifoc_txen, m_txen);
            chk("fd",   bus.fd,  m_mode == 3);
            chk("err",  bus.err, m_mode == 4);
            if (m_txen) chk("txd", bus.fifoc_txd, m_txd);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (bus.fifoc_txen) cap.push_back(bus.fifoc_txd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_txen", bus.fifoc_txen, 1'b0);
        chk("rst_txd",  bus.fifoc_txd,  8'h00);
        chk("rst_fd",   bus.fd,  1'b0);
        chk("rst_err",  bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_frame(input int stall_at, input int stall_len, input bit rnd,
                             input int drop_at, output int ticks, output int gaps);
        int left;
        left  = 0;
        ticks = 0;
        gaps  = 0;
        bus.fs = 1'b1;
        while (!bus.fd && !bus.err && ticks < 300) begin
            tick();
            ticks++;
            if (stall_at > 0 && cap.size() == stall_at && !bus.fifoc_txen) gaps++;
            if (rnd) begin
                bus.fifoc_full = ($urandom_range(0, 3) == 0);
            end else if (left > 0) begin
                left--;
                if (left == 0) bus.fifoc_full = 1'b0;
            end else if (stall_at > 0 && bus.fifoc_txen && cap.size() == stall_at) begin
                bus.fifoc_full = 1'b1;
                left = stall_len;
            end
            if (drop_at > 0 && cap.size() >= drop_at) bus.fs = 1'b0;
        end
        if (!bus.fd && !bus.err) chk("frame_budget", 32'd0, 32'd1);
        bus.fifoc_full = 1'b0;
    endtask

    task automatic end_frame();
        bus.fs = 1'b0;
        tick();
        chk("fd_clear", bus.fd, 1'b0);
    endtask

    initial begin
        int t, g;
        logic [7:0] v [9];
        logic [7:0] s;

        rst = 1'b1;
        bus.fs = 1'b0;
        bus.fifoc_full = 1'b0;
        set_fields(f_zero);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_txen", bus.fifoc_txen, 1'b0);
        chk("init_txd",  bus.fifoc_txd,  8'h00);
        rst = 1'b0;
        m_on = 1'b1;
        chk("init_fd",  bus.fd,  1'b0);
        chk("init_err", bus.err, 1'b0);

        // Sequential payload, no back-pressure
        set_fields(f_seq);
        cap.delete();
        run_frame(0, 0, 1'b0, 0, t, g);
        chk("t1_latency", t, 14);
        chk("t1_len", cap.size(), 12);
        for (int i = 0; i < 12 && i < cap.size(); i++) chk("t1_byte", cap[i], exp1[i]);
        tick();
        chk("t1_fd_held", bus.fd, 1'b1);
        end_frame();

        // Checksum wraps modulo 256
        set_fields(f_ff);
        cap.delete();
        run_frame(0, 0, 1'b0, 0, t, g);
        chk("t2_len", cap.size(), 12);
        if (cap.size() == 12) chk("t2_check", cap[11], 8'hF7);
        chk("t2_err", bus.err, 1'b0);
        end_frame();

        // Five-cycle stall after the fourth byte
        set_fields(f_seq);
        cap.delete();
        run_frame(4, 5, 1'b0, 0, t, g);
        chk("t3_gap", g, 5);
        chk("t3_latency", t, 19);
        chk("t3_len", cap.size(), 12);
        for (int i = 0; i < 12 && i < cap.size(); i++) chk("t3_byte", cap[i], exp1[i]);
        end_frame();

        // Full raised as the checksum byte is due: it still goes out
        cap.delete();
        run_frame(11, 3, 1'b0, 0, t, g);
        chk("tl_latency", t, 14);
        if (cap.size() == 12) chk("tl_check", cap[11], 8'h2D);
        end_frame();

        // Timeout with full stuck high from the first send cycle
        cap.delete();
        bus.fs = 1'b1;
        bus.fifoc_full = 1'b1;
        repeat (9) tick();
        chk("t4_err_early", bus.err, 1'b0);
        tick();
        chk("t4_err", bus.err, 1'b1);
        bus.fs = 1'b0;
        bus.fifoc_full = 1'b0;
        repeat (4) tick();
        chk("t4_sticky", bus.err, 1'b1);
        chk("t4_nowrite", cap.size(), 0);
        do_reset();

        // Fields change after LOAD and fs drops mid-frame
        for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(1, 255));
        set_fields(v);
        cap.delete();
        bus.fs = 1'b1;
        tick();
        tick();
        set_fields(f_zero);
        run_frame(0, 0, 1'b0, 3, t, g);
        chk("t5_len", cap.size(), 12);
        s = 8'h00;
        for (int i = 0; i < 9; i++) begin
            s = s + v[i];
            if (cap.size() == 12) chk("t5_byte", cap[i + 2], v[i]);
        end
        if (cap.size() == 12) chk("t5_check", cap[11], s);
        tick();
        chk("t5_idle", bus.fd, 1'b0);

        // Reset after the sixth write, then a fresh frame
        for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(0, 255));
        set_fields(v);
        cap.delete();
        bus.fs = 1'b1;
        t = 0;
        while (cap.size() < 6 && t < 40) begin
            tick();
            t++;
        end
        chk("t6_six", cap.size(), 6);
        bus.fs = 1'b0;
        do_reset();
        tick();
        cap.delete();
        run_frame(0, 0, 1'b0, 0, t, g);
        chk("t6_len", cap.size(), 12);
        if (cap.size() == 12) begin
            chk("t6_head0", cap[0], 8'h55);
            chk("t6_head1", cap[1], 8'hAA);
        end
        end_frame();

        // Random payloads, random back-pressure and fs release points
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(0, 255));
            set_fields(v);
            cap.delete();
            run_frame(0, 0, 1'b1, int'($urandom_range(0, 12)), t, g);
            if (bus.err) begin
                do_reset();
            end else begin
                chk("rnd_len", cap.size(), 12);
                end_frame();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
